// File: rtl/burst_sink.sv
// Consumer side of a start-triggered countdown burst: arms on a rising start edge,
// accepts beats, counts them, checks the descending runner (BURST_SINK_SEQ_CHECK_EN) and aborts on stalls.
module burst_sink #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] expect_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_data,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             err_seq,
  output logic             err_timeout
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_FIN
  } state_t;

  state_t             state, state_nxt;
  logic               start_q;
  logic               arm;
  logic               seq_bad;
  logic               idle_hit;
  logic               last_beat;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   count_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               err_seq_q;
  logic               err_timeout_q;

  assign arm       = start & ~start_q;
  assign idle_hit  = (idle_q == IDLE_W'(TIMEOUT_CYC - 1));
  assign last_beat = ((count_q + CNT_W'(1)) == len_q);

`ifdef BURST_SINK_SEQ_CHECK_EN
  // Runner for the beat about to be accepted is len minus beats already taken.
  assign seq_bad = (in_data != (len_q - count_q));
`else
  logic unused_data;
  assign unused_data = ^in_data;
  assign seq_bad     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (arm) begin
          state_nxt = (expect_len == '0) ? S_FIN : S_RECV;
        end
      end
      S_RECV: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (last_beat) begin
            state_nxt = S_FIN;
          end
        end else if (idle_hit) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q       <= 1'b0;
      len_q         <= '0;
      count_q       <= '0;
      idle_q        <= '0;
      err_seq_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          if (arm) begin
            len_q         <= expect_len;
            count_q       <= '0;
            idle_q        <= '0;
            err_seq_q     <= 1'b0;
            err_timeout_q <= 1'b0;
          end
        end
        S_RECV: begin
          if (in_valid) begin
            count_q <= count_q + CNT_W'(1);
            idle_q  <= '0;
            if (seq_bad) begin
              err_seq_q <= 1'b1;
            end
          end else begin
            idle_q <= idle_q + IDLE_W'(1);
            if (idle_hit) begin
              err_timeout_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign count       = count_q;
  assign err_seq     = err_seq_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_burst_sink.sv
// Self-checking bench for burst_sink: directed scenarios plus randomized bursts
// checked against a per-burst expectation computed from the beat list.
module tb_burst_sink;

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 16;
`ifdef BURST_SINK_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] expect_len;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_data;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             err_seq;
  logic             err_timeout;

  int tests_run;
  int tests_failed;

  burst_sink #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .expect_len(expect_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .count(count), .busy(busy), .done(done),
    .err_seq(err_seq), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; expect_len = '0; in_valid = 1'b0; in_data = '0;
    tick; tick;
    tests_run++;
    if ({count, busy, in_ready, done, err_seq, err_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: count=%0d busy=%b ready=%b done=%b es=%b et=%b want all 0",
               count, busy, in_ready, done, err_seq, err_timeout);
    end
    rst = 1'b0;
    tick;
  endtask

  // Offers len beats from the list, with idle gaps, and checks the whole burst.
  task automatic run_burst(input string tag, input int unsigned len, input logic [31:0] beats[$],
                           input int unsigned gap_max, input bit gap_fixed);
    bit          early;
    bit          exp_seq;
    int unsigned gap;
    exp_seq = 1'b0;
    for (int i = 0; i < beats.size(); i++)
      if (beats[i] != 32'(len - i)) exp_seq = 1'b1;
    if (!SEQ_EN) exp_seq = 1'b0;

    start = 1'b0; in_valid = 1'b0; tick;
    expect_len = len; start = 1'b1; tick;
    tests_run++;
    if (in_ready !== 1'b1 || count !== '0) begin
      tests_failed++;
      $display("FAIL %s arm: ready=%b count=%0d want ready=1 count=0", tag, in_ready, count);
    end
    tests_run++;
    if ({err_seq, err_timeout} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s arm_clear: es=%b et=%b want 0 0", tag, err_seq, err_timeout);
    end

    early = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      gap = gap_fixed ? gap_max : $urandom_range(gap_max, 0);
      repeat (gap) begin
        in_valid = 1'b0; in_data = $urandom;
        tick;
        if (done) early = 1'b1;
      end
      in_valid = 1'b1; in_data = beats[i]; expect_len = $urandom;
      tick;
      if (i + 1 < int'(len) && done) early = 1'b1;
    end
    in_valid = 1'b0;

    tests_run++;
    if (done !== 1'b1 || early) begin
      tests_failed++;
      $display("FAIL %s done_timing: done=%b early=%b want done=1 early=0", tag, done, early);
    end
    tests_run++;
    if (count !== CNT_W'(len)) begin
      tests_failed++;
      $display("FAIL %s count: got %0d want %0d", tag, count, len);
    end
    tests_run++;
    if (err_seq !== exp_seq || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s flags: es=%b et=%b want es=%b et=0", tag, err_seq, err_timeout, exp_seq);
    end
    tick;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_done: done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q[$];
    q = '{32'd3, 32'd2, 32'd1};
    run_burst("b2b_good", 3, q, 0, 1'b1);
    q = '{32'd3, 32'd1, 32'd1};
    run_burst("b2b_badseq", 3, q, 0, 1'b1);
  endtask

  task automatic test_timeout;
    bit early;
    start = 1'b0; in_valid = 1'b0; tick;
    expect_len = 3; start = 1'b1; tick;
    in_valid = 1'b1; in_data = 3; tick;
    in_data = 2; tick;
    in_valid = 1'b0;
    early = 1'b0;
    for (int j = 1; j <= int'(TIMEOUT); j++) begin
      tick;
      if (j < int'(TIMEOUT) && (done || !busy)) early = 1'b1;
    end
    tests_run++;
    if (done !== 1'b1 || early) begin
      tests_failed++;
      $display("FAIL timeout_done: done=%b early=%b want done=1 early=0", done, early);
    end
    tests_run++;
    if (err_timeout !== 1'b1 || count !== CNT_W'(2)) begin
      tests_failed++;
      $display("FAIL timeout_flags: et=%b count=%0d want et=1 count=2", err_timeout, count);
    end
    tick;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_after: busy=%b done=%b et=%b want 0 0 1", busy, done, err_timeout);
    end
    start = 1'b0; tick;
    expect_len = 2; start = 1'b1; tick;
    tests_run++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rearm_clear: et=%b busy=%b want et=0 busy=1", err_timeout, busy);
    end
    in_valid = 1'b1; in_data = 2; tick;
    in_data = 1; tick;
    in_valid = 1'b0;
    tests_run++;
    if (done !== 1'b1 || count !== CNT_W'(2)) begin
      tests_failed++;
      $display("FAIL rearm_burst: done=%b count=%0d want done=1 count=2", done, count);
    end
    tick;
  endtask

  task automatic test_zero_len;
    start = 1'b0; in_valid = 1'b1; in_data = 0; tick;
    expect_len = 0; start = 1'b1; tick;
    tests_run++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== '0) begin
      tests_failed++;
      $display("FAIL zero_len: done=%b ready=%b count=%0d want 1 0 0", done, in_ready, count);
    end
    tick;
    tests_run++;
    if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_len_after: done=%b ready=%b busy=%b want 0 0 0", done, in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_no_rearm;
    bit bad;
    start = 1'b0; in_valid = 1'b0; tick;
    expect_len = 4; start = 1'b1; tick;
    in_valid = 1'b1; in_data = 4; tick;
    in_valid = 1'b0; start = 1'b0; tick;
    start = 1'b1; expect_len = 1; tick;
    for (int v = 3; v >= 1; v--) begin
      in_valid = 1'b1; in_data = v; tick;
    end
    in_valid = 1'b0;
    tests_run++;
    if (done !== 1'b1 || count !== CNT_W'(4) || err_seq !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_burst_edge: done=%b count=%0d es=%b want 1 4 0", done, count, err_seq);
    end
    bad = 1'b0;
    repeat (6) begin
      in_valid = 1'b1; in_data = $urandom;
      tick;
      if (busy || done || in_ready || count != CNT_W'(4)) bad = 1'b1;
    end
    in_valid = 1'b0;
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL start_held_idle: got activity busy=%b done=%b count=%0d want idle count=4",
               busy, done, count);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] q[$];
    start = 1'b0; in_valid = 1'b0; tick;
    expect_len = 3; start = 1'b1; tick;
    in_valid = 1'b1; in_data = 3; tick;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; tick;
    tests_run++;
    if ({count, busy, in_ready, done, err_seq, err_timeout} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: count=%0d busy=%b ready=%b done=%b es=%b et=%b want all 0",
               count, busy, in_ready, done, err_seq, err_timeout);
    end
    rst = 1'b0; tick;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_done: done=%b busy=%b want 0 0", done, busy);
    end
    q = '{32'd3, 32'd2, 32'd1};
    run_burst("post_reset", 3, q, 2, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] q[$];
    int unsigned len;
    int unsigned idx;
    for (int n = 0; n < 10; n++) begin
      len = $urandom_range(8, 1);
      q = {};
      for (int i = 0; i < int'(len); i++) q.push_back(32'(len - i));
      if ($urandom_range(1, 0) == 1) begin
        idx = $urandom_range(len - 1, 0);
        q[idx] = q[idx] + 32'($urandom_range(5, 1));
      end
      run_burst($sformatf("rand%0d", n), len, q, 3, 1'b0);
    end
    len = 4;
    q = '{32'd4, 32'd3, 32'd2, 32'd1};
    run_burst("gap_edge", len, q, TIMEOUT - 1, 1'b1);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset;
    test_back_to_back;
    test_timeout;
    test_zero_len;
    test_no_rearm;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
